// File: rtl/read_pattern_checker.sv
// Checks a stream of read beats against a generated pattern (seed XOR index or
// seed rotated by index) and reports pass/fail, error statistics and a watchdog timeout.
module read_pattern_checker #(
    parameter int                      DATA_WIDTH    = 64,
    parameter int                      COUNT_WIDTH   = 24,
    parameter logic [DATA_WIDTH-1:0]   SEED          = DATA_WIDTH'(64'hdeadfadebabebeef),
    parameter int                      TIMEOUT_WIDTH = 20,
    parameter bit                      STOP_ON_ERROR = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   avl_rdata_valid,
    input  logic [DATA_WIDTH-1:0]  avl_rdata,
    input  logic                   ddr3_init_done,
    input  logic                   ddr3_cal_success,
    input  logic                   ddr3_cal_fail,
    input  logic                   mode,
    output logic                   is_finished,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [15:0]            error_count,
    output logic [COUNT_WIDTH-1:0] first_error_index,
    output logic [COUNT_WIDTH:0]   beats_checked,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        WAIT_FOR_INIT = 2'd0,
        CHECK         = 2'd1,
        ERROR         = 2'd2,
        FINISHED      = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     mode_q, mode_d;
    logic [COUNT_WIDTH:0]     beats_q, beats_d;
    logic [15:0]              err_q, err_d;
    logic [COUNT_WIDTH-1:0]   first_q, first_d;
    logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
    logic                     fin_q, fin_d;
    logic                     pass_q, pass_d;
    logic                     fail_q, fail_d;
    logic                     timeout_q, timeout_d;

    logic [COUNT_WIDTH-1:0]   idx;
    logic [31:0]              rot_amt;
    logic [DATA_WIDTH-1:0]    xor_word;
    logic [DATA_WIDTH-1:0]    rot_word;
    logic [DATA_WIDTH-1:0]    expected;
    logic                     match;
    logic [TIMEOUT_WIDTH-1:0] wdog_inc;

    // Expected word for the current beat index, compared combinationally in the receive cycle.
    always_comb begin
        idx      = beats_q[COUNT_WIDTH-1:0];
        xor_word = SEED ^ DATA_WIDTH'(idx);
        rot_amt  = 32'(idx) % 32'(DATA_WIDTH);
        rot_word = (SEED << rot_amt) | (SEED >> (32'(DATA_WIDTH) - rot_amt));
        expected = mode_q ? rot_word : xor_word;
        match    = (avl_rdata == expected);
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        beats_d   = beats_q;
        err_d     = err_q;
        first_d   = first_q;
        wdog_d    = wdog_q;
        fin_d     = fin_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        wdog_inc  = wdog_q + 1'b1;

        case (state_q)
            WAIT_FOR_INIT: begin
                if (ddr3_init_done && ddr3_cal_success) begin
                    state_d = CHECK;
                    mode_d  = mode;
                    wdog_d  = '0;
                end else if (ddr3_init_done && ddr3_cal_fail) begin
                    state_d = ERROR;
                    fin_d   = 1'b1;
                    fail_d  = 1'b1;
                end
            end
            CHECK: begin
                // Completion outranks any beat arriving in the same cycle.
                if (beats_q[COUNT_WIDTH]) begin
                    fin_d = 1'b1;
                    if (err_q == 16'd0) begin
                        state_d = FINISHED;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                        fail_d  = 1'b1;
                    end
                end else if (avl_rdata_valid) begin
                    wdog_d = '0;
                    if (match) begin
                        beats_d = beats_q + 1'b1;
                    end else begin
                        if (err_q != 16'hffff) err_d = err_q + 16'd1;
                        if (err_q == 16'd0) first_d = idx;
                        if (STOP_ON_ERROR) begin
                            state_d = ERROR;
                            fin_d   = 1'b1;
                            fail_d  = 1'b1;
                        end else begin
                            beats_d = beats_q + 1'b1;
                        end
                    end
                end else begin
                    // Fires on the edge where the counter reaches all-ones.
                    wdog_d = wdog_inc;
                    if (&wdog_inc) begin
                        state_d   = ERROR;
                        fin_d     = 1'b1;
                        fail_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_FOR_INIT;
            mode_q    <= 1'b0;
            beats_q   <= '0;
            err_q     <= '0;
            first_q   <= '0;
            wdog_q    <= '0;
            fin_q     <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            beats_q   <= beats_d;
            err_q     <= err_d;
            first_q   <= first_d;
            wdog_q    <= wdog_d;
            fin_q     <= fin_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
        end
    end

    assign is_finished       = fin_q;
    assign pass              = pass_q;
    assign fail              = fail_q;
    assign timeout           = timeout_q;
    assign error_count       = err_q;
    assign first_error_index = first_q;
    assign beats_checked     = beats_q;
    assign state_dbg         = state_q;

endmodule
